// File: rtl/imu_frame_parser.sv
// Parses framed IMU samples (0xAA 0x55, 12 payload bytes, additive checksum) from a UART byte stream
// and presents the last good frame as six sign-extended 32-bit words, with health counters.
module imu_frame_parser #(
  parameter int TIMEOUT_CLKS = 8680
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic [31:0] ax,
  output logic [31:0] ay,
  output logic [31:0] az,
  output logic [31:0] gx,
  output logic [31:0] gy,
  output logic [31:0] gz,
  output logic        data_ready,
  output logic        in_sync,
  output logic [7:0]  cksum_err_cnt,
  output logic [7:0]  timeout_cnt,
  output logic [15:0] frame_cnt
);

  localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {WAIT_H1, WAIT_H2, PAYLOAD, CHECKSUM} state_t;

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        shadow_q [12];
  logic [7:0]        shadow_d [12];
  logic [31:0]       out_q [6];
  logic [31:0]       out_d [6];
  logic [31:0]       frame_word [6];
  logic              data_ready_q, data_ready_d;
  logic              in_sync_q, in_sync_d;
  logic [7:0]        cksum_err_cnt_q, cksum_err_cnt_d;
  logic [7:0]        timeout_cnt_q, timeout_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              gap_expired;

  // Each little-endian int16 pair in the shadow buffer becomes one sign-extended output word.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_word
      assign frame_word[gi] = {{16{shadow_q[2*gi+1][7]}}, shadow_q[2*gi+1], shadow_q[2*gi]};
    end
  endgenerate

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    sum_d           = sum_q;
    shadow_d        = shadow_q;
    out_d           = out_q;
    data_ready_d    = 1'b0;
    cksum_err_cnt_d = cksum_err_cnt_q;
    timeout_cnt_d   = timeout_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    gap_expired     = 1'b0;

    if (state_q == WAIT_H1 || rx_dv) begin
      gap_d = '0;
    end else begin
      gap_d       = gap_q + 1'b1;
      gap_expired = (gap_d == GAP_LIMIT);
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    if (rx_dv) begin
      case (state_q)
        WAIT_H1: begin
          if (rx_byte == 8'hAA) state_d = WAIT_H2;
        end
        WAIT_H2: begin
          if (rx_byte == 8'h55) begin
            state_d = PAYLOAD;
            idx_d   = 4'd0;
            sum_d   = 8'd0;
          end else if (rx_byte != 8'hAA) begin
            state_d = WAIT_H1;
          end
        end
        PAYLOAD: begin
          shadow_d[idx_q] = rx_byte;
          sum_d           = sum_q + rx_byte;
          idx_d           = idx_q + 4'd1;
          if (idx_q == 4'd11) state_d = CHECKSUM;
        end
        CHECKSUM: begin
          state_d = WAIT_H1;
          if (rx_byte == sum_q) begin
            for (int k = 0; k < 6; k++) out_d[k] = frame_word[k];
            data_ready_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end else if (cksum_err_cnt_q != 8'hFF) begin
            cksum_err_cnt_d = cksum_err_cnt_q + 8'd1;
          end
        end
        default: state_d = WAIT_H1;
      endcase
    end else if (gap_expired) begin
      state_d = WAIT_H1;
      gap_d   = '0;
      if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
    end

    in_sync_d = (state_d == PAYLOAD) || (state_d == CHECKSUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= WAIT_H1;
      idx_q           <= '0;
      sum_q           <= '0;
      gap_q           <= '0;
      data_ready_q    <= 1'b0;
      in_sync_q       <= 1'b0;
      cksum_err_cnt_q <= '0;
      timeout_cnt_q   <= '0;
      frame_cnt_q     <= '0;
      for (int k = 0; k < 12; k++) shadow_q[k] <= '0;
      for (int k = 0; k < 6; k++) out_q[k] <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      sum_q           <= sum_d;
      gap_q           <= gap_d;
      data_ready_q    <= data_ready_d;
      in_sync_q       <= in_sync_d;
      cksum_err_cnt_q <= cksum_err_cnt_d;
      timeout_cnt_q   <= timeout_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      shadow_q        <= shadow_d;
      out_q           <= out_d;
    end
  end

  assign ax            = out_q[0];
  assign ay            = out_q[1];
  assign az            = out_q[2];
  assign gx            = out_q[3];
  assign gy            = out_q[4];
  assign gz            = out_q[5];
  assign data_ready    = data_ready_q;
  assign in_sync       = in_sync_q;
  assign cksum_err_cnt = cksum_err_cnt_q;
  assign timeout_cnt   = timeout_cnt_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_imu_frame_parser.sv
// Directed bench for imu_frame_parser: a table of frames with expected results, then hand-written
// sequences for resync, timeout, mid-frame reset and counter saturation.
module tb_imu_frame_parser;

  localparam int TO = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [31:0] ax, ay, az, gx, gy, gz;
  logic        data_ready, in_sync;
  logic [7:0]  cksum_err_cnt, timeout_cnt;
  logic [15:0] frame_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int dr_seen = 0;

  imu_frame_parser #(.TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .ax(ax), .ay(ay), .az(az), .gx(gx), .gy(gy), .gz(gz),
    .data_ready(data_ready), .in_sync(in_sync),
    .cksum_err_cnt(cksum_err_cnt), .timeout_cnt(timeout_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Counts data_ready cycles; a pulse longer than one cycle is counted more than once.
  always @(negedge clk) if (data_ready === 1'b1) dr_seen++;

  // Payload literal is written first byte leftmost.
  typedef struct packed {
    logic [95:0] pl;
    logic [7:0]  ck;
    logic        good;
    logic [31:0] eax, eay, eaz, egx, egy, egz;
    logic [15:0] fcnt;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_pl(input logic [95:0] pl, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(pl[95-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [95:0] pl, input logic [7:0] ck);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(pl, 0, 11);
    send_byte(ck);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".ax"}, ax, v.eax);
    chk({tag, ".ay"}, ay, v.eay);
    chk({tag, ".az"}, az, v.eaz);
    chk({tag, ".gx"}, gx, v.egx);
    chk({tag, ".gy"}, gy, v.egy);
    chk({tag, ".gz"}, gz, v.egz);
  endtask

  initial begin
    int dr_before;

    vecs[0] = '{96'h00_01_38_FF_00_40_01_00_FF_FF_00_00, 8'h77, 1'b1,
                32'd256, -32'sd200, 32'd16384, 32'd1, -32'sd1, 32'd0, 16'd1, 8'd0};
    vecs[1] = '{96'h00_01_38_FF_00_40_01_00_FF_FF_00_00, 8'h78, 1'b0,
                32'd256, -32'sd200, 32'd16384, 32'd1, -32'sd1, 32'd0, 16'd1, 8'd1};
    vecs[2] = '{96'h00_80_FF_7F_01_80_FE_FF_34_12_CC_ED, 8'h7B, 1'b1,
                -32'sd32768, 32'd32767, -32'sd32767, -32'sd2, 32'd4660, -32'sd4660, 16'd2, 8'd1};
    vecs[3] = '{96'hAA_55_AA_55_AA_AA_55_55_00_00_AA_00, 8'hA6, 1'b1,
                32'd21930, 32'd21930, -32'sd21846, 32'd21845, 32'd0, 32'd170, 16'd3, 8'd1};
    vecs[4] = '{96'h0, 8'h00, 1'b1,
                32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd4, 8'd1};
    vecs[5] = '{96'h0, 8'h01, 1'b0,
                32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 16'd4, 8'd2};

    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ax", ax, 32'd0);
    chk("rst.gz", gz, 32'd0);
    chk("rst.data_ready", {31'd0, data_ready}, 32'd0);
    chk("rst.in_sync", {31'd0, in_sync}, 32'd0);
    chk("rst.frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst.cksum_err_cnt", {24'd0, cksum_err_cnt}, 32'd0);
    chk("rst.timeout_cnt", {24'd0, timeout_cnt}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Table frames are sent back to back with rx_dv held high across frame boundaries.
    dr_before = dr_seen;
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].pl, vecs[v].ck);
      $display("vec %0d: ck=%02h data_ready=%0b frame_cnt=%0d cksum_err_cnt=%0d",
               v, vecs[v].ck, data_ready, frame_cnt, cksum_err_cnt);
      chk($sformatf("vec%0d.data_ready", v), {31'd0, data_ready}, {31'd0, vecs[v].good});
      chk($sformatf("vec%0d.in_sync", v), {31'd0, in_sync}, 32'd0);
      chk($sformatf("vec%0d.frame_cnt", v), {16'd0, frame_cnt}, {16'd0, vecs[v].fcnt});
      chk($sformatf("vec%0d.cksum_err_cnt", v), {24'd0, cksum_err_cnt}, {24'd0, vecs[v].ecnt});
      chk_outs($sformatf("vec%0d", v), vecs[v]);
    end
    idle(1);
    chk("table.pulses", dr_seen - dr_before, 32'd4);
    chk("table.data_ready_low", {31'd0, data_ready}, 32'd0);

    // Noise byte, then AA AA 55 must still lock onto the frame.
    dr_before = dr_seen;
    send_byte(8'h12);
    send_byte(8'hAA);
    send_frame(vecs[2].pl, vecs[2].ck);
    $display("noise+sync: data_ready=%0b frame_cnt=%0d", data_ready, frame_cnt);
    chk("sync.data_ready", {31'd0, data_ready}, 32'd1);
    chk("sync.frame_cnt", {16'd0, frame_cnt}, 32'd5);
    chk_outs("sync", vecs[2]);
    idle(2);
    chk("sync.pulses", dr_seen - dr_before, 32'd1);

    // Timeout fires after exactly TO idle cycles inside a frame.
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(vecs[0].pl, 0, 4);
    chk("to.in_sync_mid", {31'd0, in_sync}, 32'd1);
    idle(TO - 1);
    chk("to.not_yet", {24'd0, timeout_cnt}, 32'd0);
    chk("to.in_sync_hold", {31'd0, in_sync}, 32'd1);
    idle(1);
    $display("timeout: timeout_cnt=%0d in_sync=%0b", timeout_cnt, in_sync);
    chk("to.timeout_cnt", {24'd0, timeout_cnt}, 32'd1);
    chk("to.in_sync", {31'd0, in_sync}, 32'd0);
    send_frame(vecs[0].pl, vecs[0].ck);
    chk("to.after.data_ready", {31'd0, data_ready}, 32'd1);
    chk("to.after.frame_cnt", {16'd0, frame_cnt}, 32'd6);
    chk_outs("to.after", vecs[0]);
    idle(1);

    // A byte on the cycle the timeout would fire keeps the frame alive.
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(vecs[3].pl, 0, 2);
    idle(TO - 1);
    send_pl(vecs[3].pl, 3, 11);
    send_byte(vecs[3].ck);
    $display("edge timeout: data_ready=%0b timeout_cnt=%0d", data_ready, timeout_cnt);
    chk("toedge.data_ready", {31'd0, data_ready}, 32'd1);
    chk("toedge.timeout_cnt", {24'd0, timeout_cnt}, 32'd1);
    chk("toedge.frame_cnt", {16'd0, frame_cnt}, 32'd7);
    chk_outs("toedge", vecs[3]);
    idle(1);

    // Reset after byte 8 of a frame discards it; the tail must not produce a pulse.
    dr_before = dr_seen;
    send_byte(8'hAA);
    send_byte(8'h55);
    send_pl(vecs[0].pl, 0, 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_pl(vecs[0].pl, 6, 11);
    send_byte(vecs[0].ck);
    idle(2);
    $display("mid reset: pulses=%0d frame_cnt=%0d", dr_seen - dr_before, frame_cnt);
    chk("midrst.pulses", dr_seen - dr_before, 32'd0);
    chk("midrst.frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("midrst.cksum_err_cnt", {24'd0, cksum_err_cnt}, 32'd0);
    chk("midrst.timeout_cnt", {24'd0, timeout_cnt}, 32'd0);
    chk("midrst.ax", ax, 32'd0);
    send_frame(vecs[0].pl, vecs[0].ck);
    chk("midrst.next.data_ready", {31'd0, data_ready}, 32'd1);
    chk("midrst.next.frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk_outs("midrst.next", vecs[0]);
    idle(1);

    // 300 bad frames saturate the checksum error counter.
    dr_before = dr_seen;
    for (int i = 0; i < 300; i++) send_frame(vecs[5].pl, vecs[5].ck);
    idle(1);
    $display("saturation: cksum_err_cnt=%0d pulses=%0d", cksum_err_cnt, dr_seen - dr_before);
    chk("sat.cksum_err_cnt", {24'd0, cksum_err_cnt}, 32'd255);
    chk("sat.pulses", dr_seen - dr_before, 32'd0);
    chk("sat.frame_cnt_hold", {16'd0, frame_cnt}, 32'd1);
    send_frame(vecs[2].pl, vecs[2].ck);
    chk("sat.good.data_ready", {31'd0, data_ready}, 32'd1);
    chk("sat.good.frame_cnt", {16'd0, frame_cnt}, 32'd2);
    chk("sat.good.cksum_err_cnt", {24'd0, cksum_err_cnt}, 32'd255);
    chk_outs("sat.good", vecs[2]);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
